pic_command_decoder: RTL and testbench
======================================

Name: pic_command_decoder

Overview:
- Write-side counterpart of the 8259A mask/status read path: decodes CPU bus writes into ICW1–ICW4 and OCW1–OCW3, and generates the register read selects.
- Produces the OCW1 mask byte consumed by the mask register and the IRR.
- Produces the readIMR, readIRR and readISR selects that gate the internal data bus.
- Sits between the data bus buffer / read-write pins and the control logic.

Parameters:
- ICW4_DEFAULT, 8'h00, value loaded into icw4 on ICW1 (8259A clears ICW4 bits on init).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low; one clock, all state in clk domain
- cs_n  in  1  chip select, active-low
- wr_n  in  1  write strobe, active-low
- rd_n  in  1  read strobe, active-low
- a0  in  1  address bit
- dataIn  in  8  internal data bus, write direction
- ocw1  out  8  interrupt mask byte (bit=1 → IR masked)
- icw1  out  8  latched ICW1 (LTIM=bit3, SNGL=bit1, IC4=bit0)
- icw2  out  8  latched ICW2 (vector base bits 7:3)
- icw3  out  8  latched ICW3 (slave map / slave ID)
- icw4  out  8  latched ICW4 (AEOI=bit1, uPM=bit0)
- ocw2Cmd  out  8  last OCW2 byte (R, SL, EOI, L2..L0)
- ocw2Valid  out  1  one-cycle pulse when ocw2Cmd is updated
- initDone  out  1  initialisation sequence complete
- readIMR  out  1  drive mask onto internal bus
- readIRR  out  1  drive IRR onto internal bus
- readISR  out  1  drive ISR onto internal bus
- specialMask  out  1  special mask mode (see Optional Feature)

Behaviour:
- Write capture:
  - While cs_n=0 and wr_n=0, register a0 and dataIn every clk; set pending flag.
  - Commit on the first clk where wr_n=1 and pending=1; clear pending.
  - Register outputs update on that same clk edge, so they are visible one cycle after wr_n rises.
  - cs_n rising during a pending write does not cancel it; the last captured values are used.
- State machine: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY. Reset state is UNINIT.
- Any state, commit with a0=0 and d4=1 → ICW1:
  - latch icw1; ocw1←8'h00; icw4←ICW4_DEFAULT; read select←IRR; specialMask←0; initDone←0.
  - next state WAIT_ICW2.
- WAIT_ICW2, commit a0=1 → latch icw2.
  - If SNGL=0 → WAIT_ICW3.
  - Else if IC4=1 → WAIT_ICW4.
  - Else → READY.
- WAIT_ICW3, commit a0=1 → latch icw3; IC4 ? WAIT_ICW4 : READY.
- WAIT_ICW4, commit a0=1 → latch icw4; → READY.
- Commits with a0=0, d4=0 in UNINIT or WAIT_* states: ignored, state unchanged.
- Commits with a0=1 in UNINIT: ignored.
- READY (initDone=1):
  - a0=1 → ocw1←data.
  - a0=0, d4=0, d3=0 → ocw2Cmd←data; ocw2Valid=1 for exactly one cycle.
  - a0=0, d4=0, d3=1 → OCW3.
- OCW3 read-register field:
  - RR (bit1)=1 → read select←RIS (bit0): 1=ISR, 0=IRR.
  - RR=0 → read select unchanged.
- Read selects (combinational):
  - rdActive = cs_n=0 and rd_n=0.
  - readIMR = rdActive & a0.
  - readIRR = rdActive & ~a0 & ~sel.
  - readISR = rdActive & ~a0 & sel.
  - At most one of the three selects is high at any time.
- Simultaneous rd_n=0 and wr_n=0: the write is captured; all read selects are forced 0.
- Reset values:
  - ocw1, icw1, icw2, icw3, ocw2Cmd = 8'h00; icw4 = ICW4_DEFAULT.
  - ocw2Valid=0, initDone=0, specialMask=0, read select=IRR, pending=0.
- rst_n=0 mid-sequence or mid-write: next clk returns to UNINIT with reset values; the pending write is discarded.

Optional Feature:
- Macro PIC_SPECIAL_MASK_EN.
- Defined:
  - OCW3 with ESMM (bit6)=1 loads specialMask←SMM (bit5).
  - ESMM=0 leaves specialMask unchanged.
  - ICW1 clears specialMask.
- Undefined: specialMask tied 0; bits 6:5 of OCW3 ignored.

Decomposition:
- Package pic_pkg:
  - state enum {UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY}.
  - Bit-index constants: ICW1_IC4, ICW1_SNGL, ICW1_LTIM, CMD_D4, CMD_D3, OCW3_RR, OCW3_RIS, OCW3_SMM, OCW3_ESMM.
- One sub-module, pic_bus_write_capture: holds the capture/pending/commit logic and outputs commitPulse, commitA0, commitData.

Test Plan:
- Init, single mode: ICW1=8'h13 (a0=0), then ICW2=8'h20 (a0=1) → icw4←8'h00 on ICW1; ICW2 skips WAIT_ICW3 → WAIT_ICW4; ICW4=8'h01 → initDone=1, icw2=8'h20, icw4=8'h01, icw3=8'h00.
- Cascade without ICW4: ICW1=8'h10, ICW2=8'h08, ICW3=8'h04 → initDone=1, icw3=8'h04, icw4 stays 8'h00.
- Mask write and read-back: in READY write a0=1, data 8'hA5 → ocw1=8'hA5 one cycle after wr_n rises; then rd_n=0 with a0=1 → readIMR=1, readIRR=readISR=0.
- OCW2/OCW3: write 8'h20 (a0=0) → ocw2Cmd=8'h20 with a single-cycle ocw2Valid. Write 8'h0B → readISR on a0=0 reads. Write 8'h08 (RR=0) → selection unchanged.
- Re-init mid-operation: ocw1=8'hFF, then ICW1=8'h13 → ocw1=8'h00, initDone=0, read select=IRR; an OCW2 write before ICW2 is ignored (no ocw2Valid).
- Reset during a pending write: wr_n low with data 8'h5A, assert rst_n=0 for 1 clk, then release wr_n → no commit; all outputs at reset values. With PIC_SPECIAL_MASK_EN defined, OCW3=8'h68 → specialMask=1.

Source files
------------

// File: rtl/pic_command_decoder_pkg.sv
// pic_pkg: shared state encoding and command-byte bit positions for the 8259A write decoder.
package pic_pkg;
    typedef enum logic [2:0] {UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;
    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_LTIM = 3;
    localparam int CMD_D4    = 4;
    localparam int CMD_D3    = 3;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_RIS  = 0;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_ESMM = 6;
endpackage

// File: rtl/pic_command_decoder_bus_write_capture.sv
// pic_bus_write_capture: samples a0/data while a write strobe is low and commits on the strobe's release.
module pic_bus_write_capture
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] dataIn,
    output logic       commitPulse,
    output logic       commitA0,
    output logic [7:0] commitData
);
    logic pending;

    // cs_n may rise before wr_n; the last captured values still commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            commitA0   <= 1'b0;
            commitData <= 8'h00;
        end else if (!cs_n && !wr_n) begin
            pending    <= 1'b1;
            commitA0   <= a0;
            commitData <= dataIn;
        end else if (wr_n) begin
            pending <= 1'b0;
        end
    end

    assign commitPulse = pending & wr_n;
endmodule

// File: rtl/pic_command_decoder.sv
// pic_command_decoder: decodes 8259A ICW1-4 / OCW1-3 writes and generates register read selects.
// Define PIC_SPECIAL_MASK_EN to enable OCW3 special mask mode control.
module pic_command_decoder
    import pic_pkg::*;
#(
    parameter logic [7:0] ICW4_DEFAULT = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic       a0,
    input  logic [7:0] dataIn,
    output logic [7:0] ocw1,
    output logic [7:0] icw1,
    output logic [7:0] icw2,
    output logic [7:0] icw3,
    output logic [7:0] icw4,
    output logic [7:0] ocw2Cmd,
    output logic       ocw2Valid,
    output logic       initDone,
    output logic       readIMR,
    output logic       readIRR,
    output logic       readISR,
    output logic       specialMask
);
    state_t     state;
    logic       sel;
    logic       c_pulse;
    logic       c_a0;
    logic [7:0] c_data;
    logic       is_icw1;
    logic       rd_active;

    pic_bus_write_capture u_capture (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .wr_n       (wr_n),
        .a0         (a0),
        .dataIn     (dataIn),
        .commitPulse(c_pulse),
        .commitA0   (c_a0),
        .commitData (c_data)
    );

    assign is_icw1 = !c_a0 && c_data[CMD_D4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= UNINIT;
            ocw1      <= 8'h00;
            icw1      <= 8'h00;
            icw2      <= 8'h00;
            icw3      <= 8'h00;
            icw4      <= ICW4_DEFAULT;
            ocw2Cmd   <= 8'h00;
            ocw2Valid <= 1'b0;
            initDone  <= 1'b0;
            sel       <= 1'b0;
        end else begin
            ocw2Valid <= 1'b0;
            if (c_pulse && is_icw1) begin
                icw1     <= c_data;
                ocw1     <= 8'h00;
                icw4     <= ICW4_DEFAULT;
                sel      <= 1'b0;
                initDone <= 1'b0;
                state    <= WAIT_ICW2;
            end else if (c_pulse) begin
                case (state)
                    WAIT_ICW2: if (c_a0) begin
                        icw2     <= c_data;
                        state    <= !icw1[ICW1_SNGL] ? WAIT_ICW3 : icw1[ICW1_IC4] ? WAIT_ICW4 : READY;
                        initDone <= icw1[ICW1_SNGL] && !icw1[ICW1_IC4];
                    end
                    WAIT_ICW3: if (c_a0) begin
                        icw3     <= c_data;
                        state    <= icw1[ICW1_IC4] ? WAIT_ICW4 : READY;
                        initDone <= !icw1[ICW1_IC4];
                    end
                    WAIT_ICW4: if (c_a0) begin
                        icw4     <= c_data;
                        state    <= READY;
                        initDone <= 1'b1;
                    end
                    READY: begin
                        if (c_a0) ocw1 <= c_data;
                        else if (!c_data[CMD_D3]) begin
                            ocw2Cmd   <= c_data;
                            ocw2Valid <= 1'b1;
                        end else if (c_data[OCW3_RR]) sel <= c_data[OCW3_RIS];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PIC_SPECIAL_MASK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) specialMask <= 1'b0;
        else if (c_pulse && is_icw1) specialMask <= 1'b0;
        else if (c_pulse && state == READY && !c_a0 && c_data[CMD_D3] && c_data[OCW3_ESMM])
            specialMask <= c_data[OCW3_SMM];
    end
`else
    assign specialMask = 1'b0;
`endif

    // a simultaneous write wins over the read
    assign rd_active = !cs_n && !rd_n && wr_n;
    assign readIMR   = rd_active && a0;
    assign readIRR   = rd_active && !a0 && !sel;
    assign readISR   = rd_active && !a0 && sel;
endmodule

// File: tb/tb_pic_command_decoder.sv
// tb_pic_command_decoder: directed plan plus randomized bus writes checked against a behavioural model.
module tb_pic_command_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic [7:0] ocw1, icw1, icw2, icw3, icw4, ocw2Cmd;
    logic       ocw2Valid, initDone, readIMR, readIRR, readISR, specialMask;

    pic_command_decoder dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
        .dataIn(dataIn), .ocw1(ocw1), .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .ocw2Cmd(ocw2Cmd), .ocw2Valid(ocw2Valid), .initDone(initDone), .readIMR(readIMR),
        .readIRR(readIRR), .readISR(readISR), .specialMask(specialMask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_ocw1, m_icw1, m_icw2, m_icw3, m_icw4, m_ocw2;
    logic       m_init, m_isr, m_sm, m_pulse;
    int         needq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ocw1 = 8'h00; m_icw1 = 8'h00; m_icw2 = 8'h00; m_icw3 = 8'h00;
        m_icw4 = 8'h00; m_ocw2 = 8'h00;
        m_init = 1'b0; m_isr = 1'b0; m_sm = 1'b0; m_pulse = 1'b0;
        needq.delete();
    endfunction

    // the outstanding init words are kept as a to-do list derived from ICW1
    function automatic void model_commit(input logic a, input logic [7:0] d);
        m_pulse = 1'b0;
        if (!a && d[4]) begin
            m_icw1 = d; m_ocw1 = 8'h00; m_icw4 = 8'h00;
            m_isr = 1'b0; m_sm = 1'b0; m_init = 1'b0;
            needq.delete();
            needq.push_back(2);
            if (!d[1]) needq.push_back(3);
            if (d[0]) needq.push_back(4);
        end else if (needq.size() > 0) begin
            if (a) begin
                int n;
                n = needq.pop_front();
                if (n == 2) m_icw2 = d;
                else if (n == 3) m_icw3 = d;
                else m_icw4 = d;
                if (needq.size() == 0) m_init = 1'b1;
            end
        end else if (m_init) begin
            if (a) m_ocw1 = d;
            else if (!d[3]) begin
                m_ocw2 = d;
                m_pulse = 1'b1;
            end else begin
                if (d[1]) m_isr = d[0];
`ifdef PIC_SPECIAL_MASK_EN
                if (d[6]) m_sm = d[5];
`endif
            end
        end
    endfunction

    task automatic probe_read(input logic a);
        cs_n = 1'b0; rd_n = 1'b0; a0 = a;
        #1;
        check("readIMR", readIMR, a);
        check("readIRR", readIRR, !a && !m_isr);
        check("readISR", readISR, !a && m_isr);
        rd_n = 1'b1; cs_n = 1'b1;
    endtask

    task automatic check_all();
        check("ocw1", ocw1, m_ocw1);
        check("icw1", icw1, m_icw1);
        check("icw2", icw2, m_icw2);
        check("icw3", icw3, m_icw3);
        check("icw4", icw4, m_icw4);
        check("ocw2Cmd", ocw2Cmd, m_ocw2);
        check("initDone", initDone, m_init);
        check("specialMask", specialMask, m_sm);
        probe_read(1'b1);
        probe_read(1'b0);
    endtask

    task automatic do_write(input logic a, input logic [7:0] d, input int hold);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a0 = a; dataIn = d;
        repeat (hold) @(negedge clk);
        rd_n = 1'b0;
        #1;
        check("rd_during_wr", {readIMR, readIRR, readISR}, 3'b000);
        rd_n = 1'b1;
        wr_n = 1'b1;
        cs_n = 1'($urandom_range(0, 1));
        a0 = 1'($urandom_range(0, 1));
        dataIn = 8'($urandom);
        model_commit(a, d);
        @(negedge clk);
        cs_n = 1'b1;
        check("ocw2Valid", ocw2Valid, m_pulse);
        check_all();
        @(negedge clk);
        check("ocw2Valid_drop", ocw2Valid, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("ocw2Valid_rst", ocw2Valid, 1'b0);
        check_all();
        // single mode with ICW4
        do_write(1'b0, 8'h13, 1);
        do_write(1'b1, 8'h20, 2);
        do_write(1'b1, 8'h01, 1);
        // cascade without ICW4
        do_write(1'b0, 8'h10, 1);
        do_write(1'b1, 8'h08, 1);
        do_write(1'b1, 8'h04, 3);
        do_write(1'b1, 8'hA5, 1);
        do_write(1'b0, 8'h20, 1);
        do_write(1'b0, 8'h0B, 1);
        do_write(1'b0, 8'h08, 1);
        do_write(1'b1, 8'hFF, 1);
        // re-init mid-operation, OCW2 before ICW2 must be ignored
        do_write(1'b0, 8'h13, 1);
        do_write(1'b0, 8'h20, 1);
        do_write(1'b1, 8'h20, 1);
        do_write(1'b1, 8'h01, 1);
        do_write(1'b0, 8'h68, 1);
        do_write(1'b0, 8'h0A, 2);
        // reset while an ICW1-looking write is pending
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b0; dataIn = 8'h5A;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("ocw2Valid_rstwr", ocw2Valid, 1'b0);
        check_all();
        for (int i = 0; i < 300; i++) begin
            logic       a;
            logic [7:0] d;
            a = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if (!a && d[4] && $urandom_range(0, 5) != 0) d[4] = 1'b0;
            do_write(a, d, int'($urandom_range(1, 3)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
